// File: rtl/array_loader_if.sv
// array_loader_if: the byte stream that fills the array.
//
// Handshake: the producer drives In_Data/In_Valid; the loader drives In_Ready.
// A byte is transferred on a rising Clk edge where In_Valid and In_Ready are
// both 1. In_Ready depends only on the loader's state, never on In_Valid,
// so the producer may let it steer In_Valid without creating a loop.
// The producer keeps In_Data stable while In_Valid is 1 and In_Ready is 0.
interface array_loader_if;
   logic [7:0] In_Data;
   logic       In_Valid;
   logic       In_Ready;

   // Producer side
   modport master (
      output In_Data,
      output In_Valid,
      input  In_Ready
   );

   // Loader side
   modport slave (
      input  In_Data,
      input  In_Valid,
      output In_Ready
   );
endinterface

// File: rtl/array_loader.sv
// array_loader: fills a 16 x 8-bit array from a valid/ready byte stream,
// then pulses Start for one cycle and waits for the min/max finder to report
// Finder_Done before returning to idle.
//
// The array is freely readable through Rd_Addr/Rd_Data in every state.
// The array contents are not reset; only control state is.
//
// Optional feature: define ARRAY_LOADER_CHECKSUM_EN to add a Checksum[7:0]
// output holding the mod-256 sum of the bytes accepted in the current load.
module array_loader (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Begin,
   array_loader_if.slave     in_if,
   input  logic [3:0]        Rd_Addr,
   output logic [7:0]        Rd_Data,
   output logic              Start,
   input  logic              Finder_Done,
   output logic [4:0]        Count,
   output logic              Qi,
   output logic              Ql,
   output logic              Qs,
   output logic              Qw
`ifdef ARRAY_LOADER_CHECKSUM_EN
   ,
   output logic [7:0]        Checksum
`endif
);

   // One-hot encoding; the flag outputs are the state bits themselves.
   typedef enum logic [3:0] {
      INI  = 4'b0001,
      LOAD = 4'b0010,
      STRT = 4'b0100,
      WAIT = 4'b1000
   } state_t;

   state_t     state;
   state_t     state_nxt;

   logic [7:0] mem [16];
   logic [3:0] wr_idx;
   logic       in_ready;
   logic       start_pulse;
   logic       xfer;
   logic       begin_load;

   // A transfer only happens in LOAD; In_Ready is 1 exactly there, so this
   // is the same as In_Valid && In_Ready without reading our own output.
   assign xfer       = (state == LOAD) && in_if.In_Valid;
   // Begin is only meaningful while idle.
   assign begin_load = (state == INI) && Begin;

   // State register; reset forces idle at once, whatever was in progress.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= INI;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and Moore outputs, decoded from the current state only.
   always_comb begin
      state_nxt   = state;
      in_ready    = 1'b0;
      start_pulse = 1'b0;
      unique case (state)
         INI: begin
            if (Begin) begin
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            in_ready = 1'b1;
            // The 16th byte moves us on in the same edge that writes it.
            if (in_if.In_Valid && (wr_idx == 4'd15)) begin
               state_nxt = STRT;
            end
         end
         STRT: begin
            start_pulse = 1'b1;
            state_nxt   = WAIT;
         end
         WAIT: begin
            if (Finder_Done) begin
               state_nxt = INI;
            end
         end
         default: begin
            state_nxt = INI;
         end
      endcase
   end

   assign in_if.In_Ready = in_ready;
   assign Start          = start_pulse;
   assign {Qw, Qs, Ql, Qi} = state;

   // Write index and byte count: cleared when a load begins, stepped on each
   // transfer. Count keeps its final 16 through STRT, WAIT and back in INI.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wr_idx <= 4'd0;
         Count  <= 5'd0;
      end else if (begin_load) begin
         wr_idx <= 4'd0;
         Count  <= 5'd0;
      end else if (xfer) begin
         wr_idx <= wr_idx + 4'd1;
         Count  <= Count + 5'd1;
      end
   end

   // Array storage; intentionally not reset so the finder sees raw contents.
   always_ff @(posedge Clk) begin
      if (xfer) begin
         mem[wr_idx] <= in_if.In_Data;
      end
   end

   assign Rd_Data = mem[Rd_Addr];

`ifdef ARRAY_LOADER_CHECKSUM_EN
   // Running mod-256 sum of accepted bytes, restarted with each load.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         Checksum <= 8'd0;
      end else if (begin_load) begin
         Checksum <= 8'd0;
      end else if (xfer) begin
         Checksum <= Checksum + in_if.In_Data;
      end
   end
`endif

endmodule

// File: tb/tb_array_loader.sv
// tb_array_loader: self-checking bench for array_loader.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled
// at that same point, so every sample reflects the state after the edge.
module tb_array_loader;

   logic       Clk;
   logic       Reset;
   logic       Begin;
   logic [3:0] Rd_Addr;
   logic [7:0] Rd_Data;
   logic       Start;
   logic       Finder_Done;
   logic [4:0] Count;
   logic       Qi, Ql, Qs, Qw;
`ifdef ARRAY_LOADER_CHECKSUM_EN
   logic [7:0] Checksum;
`endif

   array_loader_if in_if ();

   array_loader dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .Begin       (Begin),
      .in_if       (in_if.slave),
      .Rd_Addr     (Rd_Addr),
      .Rd_Data     (Rd_Data),
      .Start       (Start),
      .Finder_Done (Finder_Done),
      .Count       (Count),
      .Qi          (Qi),
      .Ql          (Ql),
      .Qs          (Qs),
      .Qw          (Qw)
`ifdef ARRAY_LOADER_CHECKSUM_EN
      ,
      .Checksum    (Checksum)
`endif
   );

   // Clock and reset
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Scoreboard
   logic [7:0] exp_q[$];
   logic [7:0] exp_mem [16];
   logic [7:0] exp_sum;
   int         checks;
   int         failures;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Drive one load of n bytes: first, first+stp, ...; mode 0 back-to-back,
   // 1 alternating bubbles, 2 random bubbles. Begin is waved around during
   // LOAD to show it is ignored there.
   task automatic load_bytes(input int n, input logic [7:0] first,
                             input logic [7:0] stp, input int mode);
      int         sent;
      int         cyc;
      logic       v;
      logic [7:0] d;
      check("qi_before_begin", Qi, 1);
      Begin = 1'b1;
      step();
      Begin = 1'b0;
      check("ql_after_begin", Ql, 1);
      check("count_cleared", Count, 0);
`ifdef ARRAY_LOADER_CHECKSUM_EN
      check("checksum_cleared", Checksum, 0);
`endif
      exp_sum = 8'd0;
      sent = 0;
      cyc = 0;
      while (sent < n && cyc < 200) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = (cyc % 2) == 0;
            default: v = 1'($urandom_range(0, 1));
         endcase
         d = first + 8'(stp * sent);
         check("in_ready_load", in_if.In_Ready, 1);
         check("start_low_load", Start, 0);
         in_if.In_Valid = v;
         in_if.In_Data  = v ? d : 8'($urandom_range(0, 255));
         Begin          = 1'($urandom_range(0, 1));
         step();
         cyc++;
         if (v) begin
            exp_mem[sent] = d;
            exp_q.push_back(d);
            exp_sum = exp_sum + d;
            sent++;
         end
         check("count_step", Count, sent);
         if (sent < 16) check("still_load", Ql, 1);
      end
      in_if.In_Valid = 1'b0;
      Begin          = 1'b0;
      if (sent < n) check("load_timeout", sent, n);
   endtask

   // After the 16th transfer: one STRT cycle with Start, then WAIT.
   task automatic check_start_then_wait();
      check("qs_after_16", Qs, 1);
      check("start_pulse", Start, 1);
      check("in_ready_strt", in_if.In_Ready, 0);
      check("count_16_strt", Count, 16);
`ifdef ARRAY_LOADER_CHECKSUM_EN
      check("checksum", Checksum, exp_sum);
`endif
      step();
      check("qw_after_strt", Qw, 1);
      check("start_one_cycle", Start, 0);
      check("count_16_wait", Count, 16);
   endtask

   // Pop the scoreboard in address order and compare against the array.
   task automatic readback_queue();
      logic [7:0] e;
      for (int a = 0; a < 16; a++) begin
         Rd_Addr = 4'(a);
         #1;
         if (exp_q.size() == 0) begin
            check("queue_underflow", 0, 1);
         end else begin
            e = exp_q.pop_front();
            check("rd_data", Rd_Data, e);
         end
      end
   endtask

   // Compare the whole array with the model (used after ignored writes).
   task automatic readback_model(input string tag);
      for (int a = 0; a < 16; a++) begin
         Rd_Addr = 4'(a);
         #1;
         check(tag, Rd_Data, exp_mem[a]);
      end
   endtask

   task automatic finish_handshake();
      Finder_Done = 1'b1;
      step();
      Finder_Done = 1'b0;
      check("qi_after_done", Qi, 1);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      Reset = 1'b1;
      Begin = 1'b0;
      Finder_Done = 1'b0;
      Rd_Addr = 4'd0;
      in_if.In_Valid = 1'b0;
      in_if.In_Data = 8'd0;

      // Reset state
      step();
      step();
      check("rst_qi", Qi, 1);
      check("rst_flags", {Qw, Qs, Ql}, 0);
      check("rst_count", Count, 0);
      check("rst_in_ready", in_if.In_Ready, 0);
      check("rst_start", Start, 0);
`ifdef ARRAY_LOADER_CHECKSUM_EN
      check("rst_checksum", Checksum, 0);
`endif
      Reset = 1'b0;
      step();
      check("idle_qi", Qi, 1);

      // Basic back-to-back load of 10..1F
      load_bytes(16, 8'h10, 8'h01, 0);
      check_start_then_wait();
      Rd_Addr = 4'd5;
      #1;
      check("rd_addr5", Rd_Data, 8'h15);
      readback_queue();

      // Sit in WAIT with junk offered and Begin high: nothing may change
      in_if.In_Valid = 1'b1;
      in_if.In_Data  = 8'hFF;
      Begin = 1'b1;
      for (int c = 0; c < 20; c++) begin
         step();
         check("wait_hold", Qw, 1);
         check("wait_count", Count, 16);
         check("wait_in_ready", in_if.In_Ready, 0);
      end
      Begin = 1'b0;
      readback_model("wait_frozen");
      in_if.In_Valid = 1'b0;
      finish_handshake();

      // In INI, offered bytes are ignored and Count stays 16
      in_if.In_Valid = 1'b1;
      in_if.In_Data  = 8'hAA;
      for (int c = 0; c < 3; c++) begin
         step();
         check("ini_hold", Qi, 1);
         check("ini_count", Count, 16);
      end
      in_if.In_Valid = 1'b0;
      readback_model("ini_no_write");

      // Alternating bubbles
      load_bytes(16, 8'h40, 8'h03, 1);
      check_start_then_wait();
      readback_queue();
      finish_handshake();

      // Random bubbles, random-ish data
      load_bytes(16, 8'($urandom_range(0, 255)), 8'h11, 2);
      check_start_then_wait();
      readback_queue();
      finish_handshake();

      // Reset after 7 transfers: asynchronous return to idle, load abandoned
      load_bytes(7, 8'h70, 8'h01, 0);
      check("partial_in_load", Ql, 1);
      #2;
      Reset = 1'b1;
      #1;
      check("async_qi", Qi, 1);
      check("async_count", Count, 0);
      check("async_in_ready", in_if.In_Ready, 0);
      step();
      Reset = 1'b0;
      exp_q.delete();
      in_if.In_Valid = 1'b1;
      in_if.In_Data  = 8'h55;
      for (int c = 0; c < 4; c++) begin
         step();
         check("post_rst_idle", Qi, 1);
         check("post_rst_no_start", Start, 0);
         check("post_rst_count", Count, 0);
      end
      in_if.In_Valid = 1'b0;
      readback_model("post_rst_no_write");

      // Fresh full load after the abort
      load_bytes(16, 8'h80, 8'h01, 0);
      check_start_then_wait();
      readback_queue();
      finish_handshake();

`ifdef ARRAY_LOADER_CHECKSUM_EN
      // Checksum wrap: 16 x 20 sums to 0x200
      load_bytes(16, 8'h20, 8'h00, 0);
      check("checksum_wrap", Checksum, 8'h00);
      check_start_then_wait();
      readback_queue();
      finish_handshake();
      // 01..10 sums to 0x88
      load_bytes(16, 8'h01, 8'h01, 2);
      check("checksum_88", Checksum, 8'h88);
      check_start_then_wait();
      readback_queue();
      finish_handshake();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/array_loader.md
ARRAY_LOADER -- requirements
Module: array_loader

Interface
REQ-001 SHALL have port: Clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: Reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: Begin  input  1  request to start a new 16-byte load; sampled in INI only.
REQ-004 SHALL have port: In_Data  input  8  unsigned byte offered for writing.
REQ-005 SHALL have port: In_Valid  input  1  In_Data is valid this cycle.
REQ-006 SHALL have port: In_Ready  output  1  block accepts In_Data this cycle.
REQ-007 SHALL have port: Rd_Addr  input  4  read index into the array, driven by the min/max finder.
REQ-008 SHALL have port: Rd_Data  output  8  combinational M[Rd_Addr].
REQ-009 SHALL have port: Start  output  1  one-cycle pulse telling the finder the array is full.
REQ-010 SHALL have port: Finder_Done  input  1  finder's DONE-state indication.
REQ-011 SHALL have port: Count  output  5  number of bytes written in the current load, 0..16.
REQ-012 SHALL have ports: Qi, Ql, Qs, Qw  output  1 each  one-hot state flags for INI, LOAD, STRT, WAIT.

Function
REQ-013 SHALL hold storage as 16 x 8-bit registers M[0:15] plus a 4-bit write index I.
REQ-014 SHALL implement a one-hot FSM: INI=4'b0001, LOAD=4'b0010, STRT=4'b0100, WAIT=4'b1000; {Qw,Qs,Ql,Qi} = state.
REQ-015 SHALL, in INI: In_Ready=0; on Begin=1 go to LOAD and set I<=0, Count<=0; otherwise stay.
REQ-016 SHALL, in LOAD: In_Ready=1; a transfer occurs when In_Valid=1 and In_Ready=1; on transfer M[I]<=In_Data, I<=I+1, Count<=Count+1.
REQ-017 SHALL, in LOAD with a transfer while I==15, write M[15], wrap I to 0, set Count to 16, and go to STRT on that same edge.
REQ-018 SHALL, in LOAD with In_Valid=0, hold I, Count, and M unchanged; unlimited idle cycles are permitted.
REQ-019 SHALL, in STRT: In_Ready=0 and Start=1 for exactly one cycle; then go unconditionally to WAIT.
REQ-020 SHALL, in WAIT: In_Ready=0, Start=0, and M frozen; on Finder_Done=1 go to INI; otherwise stay.
REQ-021 SHALL ignore Begin outside INI and ignore In_Valid outside LOAD (no write, no count change).
REQ-022 SHALL drive Rd_Data = M[Rd_Addr] combinationally in all states; reads never stall or alter state.
REQ-023 SHALL retain Count at 16 through STRT and WAIT and clear it only on the next INI->LOAD transition.
REQ-024 SHALL decode Start, In_Ready, and Q* from state only (Moore outputs); there is no combinational path from inputs to these outputs.

Reset
REQ-025 SHALL, on Reset=1 at any time including mid-load, immediately force state=INI, I=0, Count=0, In_Ready=0, Start=0.
REQ-026 SHALL NOT reset M contents; after reset, Rd_Data of unwritten entries is X.
REQ-027 SHALL, after Reset deasserts, require a new Begin before any write; a partially loaded array is abandoned.

Configuration
REQ-028 SHALL recognise macro ARRAY_LOADER_CHECKSUM_EN.
REQ-029 SHALL, when ARRAY_LOADER_CHECKSUM_EN is defined, add output Checksum[7:0]: the mod-256 sum of bytes accepted in the current load, cleared to 0 on INI->LOAD and by Reset, and updated on the same edge as each write.
REQ-030 SHALL, when ARRAY_LOADER_CHECKSUM_EN is undefined, omit the Checksum port and its logic entirely, with all other behaviour identical.

Verification
REQ-031 Basic load: Begin pulse, then 16 back-to-back transfers of 8'h10..8'h1F -> Ql for 16 cycles; Start high for exactly 1 cycle; Rd_Addr=5 reads 8'h15; Count=16.
REQ-032 Bubbles: In_Valid toggled 1/0 during the load -> exactly 16 writes, Start asserted only after the 16th transfer; Count steps by 1 only on valid cycles.
REQ-033 Handshake with finder: stay in WAIT while Finder_Done=0 for 20 cycles, while In_Valid=1 with 8'hFF -> M unchanged; Finder_Done=1 -> INI next edge.
REQ-034 Reset mid-load: assert Reset after 7 transfers -> Qi=1, Count=0, In_Ready=0 asynchronously; no Start until a new Begin plus 16 transfers.
REQ-035 Ignored inputs: Begin asserted during LOAD/WAIT -> no I/Count reset; In_Valid during INI -> no write.
REQ-036 With ARRAY_LOADER_CHECKSUM_EN defined, load 16 x 8'h20 -> Checksum=8'h00 (wrap); load 8'h01..8'h10 -> Checksum=8'h88.
